// File: rtl/elevador_pkg.sv
// Shared types and defaults for the elevator car controller.
package elevador_pkg;

    localparam int unsigned NUM_FLOORS_DEF   = 4;
    localparam int unsigned TRAVEL_TICKS_DEF = 8;
    localparam int unsigned DOOR_TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StArrive,
        StDoorReq,
        StDoorWait
    } state_e;

    function automatic int unsigned FLOOR_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevador_sched.sv
// Combinational call scan: pending calls above, below and at the current floor.
module elevador_sched
    import elevador_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF
) (
    input  logic [NUM_FLOORS-1:0]          pending_i,
    input  logic [FLOOR_W(NUM_FLOORS)-1:0] floor_i,
    output logic                           any_above_o,
    output logic                           any_below_o,
    output logic                           here_o
);

    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        here_o      = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (i > int'(floor_i)) any_above_o = any_above_o | pending_i[i];
            if (i < int'(floor_i)) any_below_o = any_below_o | pending_i[i];
            if (i == int'(floor_i)) here_o = pending_i[i];
        end
    end

endmodule

// File: rtl/elevador_control.sv
// Elevator car controller: call latch, SCAN travel and door handshake.
// Define CALL_SYNC_EN to pass call_btn through a 2-flop synchronizer.
module elevador_control
    import elevador_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int unsigned TRAVEL_TICKS = TRAVEL_TICKS_DEF,
    parameter int unsigned DOOR_TIMEOUT = DOOR_TIMEOUT_DEF
) (
    input  logic                           clklento,
    input  logic                           rst,
    input  logic [NUM_FLOORS-1:0]          call_btn,
    input  logic                           person_in,
    output logic                           door_req,
    output logic [FLOOR_W(NUM_FLOORS)-1:0] floor,
    output logic                           moving,
    output logic                           dir_up,
    output logic                           door_busy,
    output logic [NUM_FLOORS-1:0]          pending,
    output logic                           fault
);

    localparam int unsigned FW = FLOOR_W(NUM_FLOORS);
    localparam int unsigned TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int unsigned DW = (DOOR_TIMEOUT > 1) ? $clog2(DOOR_TIMEOUT) : 1;
    localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DoorLast   = DW'(DOOR_TIMEOUT - 1);
    localparam logic [NUM_FLOORS-1:0] FloorOne = NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] calls;

`ifdef CALL_SYNC_EN
    logic [NUM_FLOORS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clklento or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= call_btn;
            sync2_q <= sync1_q;
        end
    end

    assign calls = sync2_q;
`else
    assign calls = call_btn;
`endif

    state_e                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]         travel_q, travel_d;
    logic [DW-1:0]         timer_q, timer_d;
    logic                  fault_q, fault_d;
    logic                  pin_q;
    logic                  door_req_q, moving_q, busy_q;

    logic any_above, any_below, here;
    logic completion;
    logic [NUM_FLOORS-1:0] floor_mask;

    elevador_sched #(
        .NUM_FLOORS(NUM_FLOORS)
    ) u_sched (
        .pending_i  (pending_q),
        .floor_i    (floor_q),
        .any_above_o(any_above),
        .any_below_o(any_below),
        .here_o     (here)
    );

    assign floor_mask = FloorOne << floor_q;
    assign completion = person_in & ~pin_q;

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        travel_d = travel_q;
        timer_d  = timer_q;
        fault_d  = fault_q;

        // A call for this floor while the door cycles is already being served; clear beats set.
        pending_d = pending_q | calls;
        if (state_q == StDoorReq || state_q == StDoorWait) pending_d = pending_d & ~floor_mask;

        case (state_q)
            StIdle: begin
                if (here) begin
                    state_d = StDoorReq;
                end else if (any_above) begin
                    dir_d   = 1'b1;
                    state_d = StMove;
                end else if (any_below) begin
                    dir_d   = 1'b0;
                    state_d = StMove;
                end
            end
            StMove: begin
                if (travel_q == TravelLast) begin
                    travel_d = '0;
                    floor_d  = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
                    state_d  = StArrive;
                end else begin
                    travel_d = travel_q + TW'(1);
                end
            end
            StArrive: begin
                if (here) begin
                    state_d = StDoorReq;
                end else if (dir_q ? any_above : any_below) begin
                    state_d = StMove;
                end else if (dir_q ? any_below : any_above) begin
                    dir_d   = ~dir_q;
                    state_d = StMove;
                end else begin
                    state_d = StIdle;
                end
            end
            StDoorReq: begin
                timer_d = '0;
                state_d = StDoorWait;
            end
            StDoorWait: begin
                if (completion) begin
                    state_d = StIdle;
                end else if (timer_q == DoorLast) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clklento or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            pending_q  <= '0;
            travel_q   <= '0;
            timer_q    <= '0;
            fault_q    <= 1'b0;
            pin_q      <= 1'b0;
            door_req_q <= 1'b0;
            moving_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            travel_q   <= travel_d;
            timer_q    <= timer_d;
            fault_q    <= fault_d;
            pin_q      <= person_in;
            door_req_q <= (state_d == StDoorReq);
            moving_q   <= (state_d == StMove);
            busy_q     <= (state_d == StDoorReq) || (state_d == StDoorWait);
        end
    end

    assign door_req  = door_req_q;
    assign floor     = floor_q;
    assign moving    = moving_q;
    assign dir_up    = dir_q;
    assign door_busy = busy_q;
    assign pending   = pending_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevador_control.sv
// Bench for elevador_control: procedural car model checked every cycle plus directed literals.
module tb_elevador_control;

    localparam int NF = 4;
    localparam int T  = 8;
    localparam int TO = 32;
`ifdef CALL_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic          clklento = 1'b0;
    logic          rst      = 1'b1;
    logic [NF-1:0] call_btn = '0;
    logic          person_in = 1'b0;
    logic          door_req, moving, dir_up, door_busy, fault;
    logic [1:0]    floor;
    logic [NF-1:0] pending;

    elevador_control #(
        .NUM_FLOORS  (NF),
        .TRAVEL_TICKS(T),
        .DOOR_TIMEOUT(TO)
    ) dut (
        .clklento (clklento),
        .rst      (rst),
        .call_btn (call_btn),
        .person_in(person_in),
        .door_req (door_req),
        .floor    (floor),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_busy(door_busy),
        .pending  (pending),
        .fault    (fault)
    );

    always #5 clklento = ~clklento;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the car's life as a sequential story, one commit per clock edge.
    logic [NF-1:0] m_pend, s_call, c1, c2;
    int            m_floor;
    bit            m_dir, m_mov, m_req, m_busy, m_fault, m_pin_prev, s_pin, m_abort;

    task automatic model_reset();
        m_pend = '0; m_floor = 0; m_dir = 1; m_mov = 0; m_req = 0; m_busy = 0;
        m_fault = 0; m_pin_prev = 0; c1 = '0; c2 = '0;
    endtask

    function automatic bit m_above();
        for (int i = m_floor + 1; i < NF; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below();
        for (int i = 0; i < m_floor; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic edge_wait();
        @(posedge clklento);
        if (rst) begin
            m_abort = 1;
            model_reset();
        end else begin
            s_pin = person_in;
`ifdef CALL_SYNC_EN
            s_call = c2; c2 = c1; c1 = call_btn;
`else
            s_call = call_btn;
`endif
        end
    endtask

    task automatic commit(input bit nmov, input bit nreq, input bit nbusy);
        m_pend = m_pend | s_call;
        if (m_busy) m_pend[m_floor] = 1'b0;
        m_pin_prev = s_pin;
        m_mov = nmov; m_req = nreq; m_busy = nbusy;
    endtask

    task automatic door_cycle();
        int t = 0;
        edge_wait(); if (m_abort) return;
        commit(0, 0, 1);
        forever begin
            edge_wait(); if (m_abort) return;
            if (s_pin && !m_pin_prev) begin
                commit(0, 0, 0); return;
            end
            if (t == TO - 1) begin
                m_fault = 1; commit(0, 0, 0); return;
            end
            t++;
            commit(0, 0, 1);
        end
    endtask

    task automatic travel();
        forever begin
            for (int j = 0; j < T - 1; j++) begin
                edge_wait(); if (m_abort) return;
                commit(1, 0, 0);
            end
            edge_wait(); if (m_abort) return;
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            commit(0, 0, 0);
            edge_wait(); if (m_abort) return;
            if (m_pend[m_floor]) begin
                commit(0, 1, 1); door_cycle(); return;
            end else if (m_dir ? m_above() : m_below()) begin
                commit(1, 0, 0);
            end else if (m_dir ? m_below() : m_above()) begin
                m_dir = !m_dir; commit(1, 0, 0);
            end else begin
                commit(0, 0, 0); return;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            m_abort = 0;
            edge_wait();
            if (!m_abort) begin
                if (m_pend[m_floor]) begin
                    commit(0, 1, 1); door_cycle();
                end else if (m_above()) begin
                    m_dir = 1; commit(1, 0, 0); travel();
                end else if (m_below()) begin
                    m_dir = 0; commit(1, 0, 0); travel();
                end else begin
                    commit(0, 0, 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clklento);
            #2;
            if (!rst) begin
                check("floor", int'(floor), m_floor);
                check("pending", int'(pending), int'(m_pend));
                check("moving", int'(moving), int'(m_mov));
                check("dir_up", int'(dir_up), int'(m_dir));
                check("door_req", int'(door_req), int'(m_req));
                check("door_busy", int'(door_busy), int'(m_busy));
                check("fault", int'(fault), int'(m_fault));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clklento);
    endtask

    task automatic press(input logic [NF-1:0] v);
        call_btn = v; cyc(1); call_btn = '0;
    endtask

    task automatic wait_req(input string nm);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (door_req) begin seen = 1; break; end
            cyc(1);
        end
        check(nm, int'(seen), 1);
    endtask

    task automatic wait_floor(input int f, input string nm);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (int'(floor) == f) begin seen = 1; break; end
            cyc(1);
        end
        check(nm, int'(seen), 1);
    endtask

    task automatic door_done(input string nm);
        cyc(1); person_in = 1; cyc(1);
        check(nm, int'(door_busy), 0);
        person_in = 0; cyc(1);
    endtask

    initial begin
        int busy_n, req_n;
        cyc(3);
        check("rst_floor", int'(floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_dir_up", int'(dir_up), 1);
        check("rst_door_req", int'(door_req), 0);
        rst = 0;
        cyc(2);

        // Call at the current floor: door_req one cycle after the latch edge.
        press(4'b0001); cyc(SD);
        check("s1_pending", int'(pending), 1);
        check("s1_req_early", int'(door_req), 0);
        cyc(1);
        check("s1_req", int'(door_req), 1);
        check("s1_busy", int'(door_busy), 1);
        cyc(1);
        check("s1_req_off", int'(door_req), 0);
        check("s1_pending_clr", int'(pending), 0);
        person_in = 1; cyc(1);
        check("s1_done", int'(door_busy), 0);
        person_in = 0; cyc(1);

        // Three-floor climb.
        press(4'b1000); cyc(SD);
        cyc(1);
        check("s2_moving", int'(moving), 1);
        cyc(T);
        check("s2_floor1", int'(floor), 1);
        cyc(1 + T);
        check("s2_floor2", int'(floor), 2);
        cyc(1 + T);
        check("s2_floor3", int'(floor), 3);
        check("s2_dir", int'(dir_up), 1);
        cyc(1);
        check("s2_req", int'(door_req), 1);
        door_done("s2_done");

        // SCAN: heading down, a call behind us waits until the sweep ends.
        press(4'b0001);
        wait_floor(2, "s3_reach2");
        press(4'b1000);
        wait_req("s3_req0");
        check("s3_floor0", int'(floor), 0);
        check("s3_dir0", int'(dir_up), 0);
        door_done("s3_done0");
        wait_req("s3_req3");
        check("s3_floor3", int'(floor), 3);
        check("s3_dir3", int'(dir_up), 1);
        door_done("s3_done3");

        // person_in stuck high: timeout, sticky fault; same-floor call mid-wait is dropped.
        person_in = 1; cyc(1);
        press(4'b1000);
        busy_n = 0; req_n = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 10) call_btn = 4'b1000;
            else if (i == 11) call_btn = '0;
            cyc(1);
            busy_n += int'(door_busy);
            req_n += int'(door_req);
        end
        check("s4_busy_cycles", busy_n, 1 + TO);
        check("s4_req_count", req_n, 1);
        check("s4_fault", int'(fault), 1);
        check("s4_pending", int'(pending), 0);
        person_in = 0; cyc(2);

        // Reset while travelling.
        press(4'b0001);
        wait_floor(2, "s5_reach2");
        cyc(3);
        check("s5_fault_sticky", int'(fault), 1);
        check("s5_moving", int'(moving), 1);
        rst = 1; #1;
        check("s5_floor", int'(floor), 0);
        check("s5_pending", int'(pending), 0);
        check("s5_moving_rst", int'(moving), 0);
        check("s5_fault_rst", int'(fault), 0);
        check("s5_dir_rst", int'(dir_up), 1);
        cyc(2);
        rst = 0;
        cyc(1);

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            call_btn = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
            if ($urandom_range(0, 5) == 0) person_in = ~person_in;
            if (i == 1500) rst = 1;
            if (i == 1502) rst = 0;
            cyc(1);
        end
        call_btn = '0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
